dma_sequencer: RTL and testbench
================================

DMA_SEQUENCER -- requirements
Module: dma_sequencer

Interface
REQ-001 Parameter INSTR_LENGTH, default 3, Am2940 instruction width.
REQ-002 Parameter CTRL_LENGTH, default 3, Am2940 control-register width.
REQ-003 Parameter DATA_LENGTH, default 8, address/word-count/data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request a new transfer program; honoured only when busy=0.
REQ-008 cfg_ctrl  in  CTRL_LENGTH  control word; bit 2 = address decrement, bits 1:0 = word-count mode.
REQ-009 cfg_addr, cfg_count  in  DATA_LENGTH each  start address and word count.
REQ-010 xfer_req  in  1  requester wants one transfer beat.
REQ-011 am_done  in  1  DONE flag from the Am2940 core.
REQ-012 abort  in  1  terminate the current program.
REQ-013 instr_out  out  INSTR_LENGTH  instruction driven to the Am2940 core.
REQ-014 data_out  out  DATA_LENGTH  data driven to the core's data input; data_oe  out  1  data_out valid.
REQ-015 busy, done, aborted, xfer_ack  out  1 each  status/handshake flags.
REQ-016 xfer_cnt  out  DATA_LENGTH  beats granted since the last start.

Function
REQ-017 States SHALL be IDLE, WR_CTRL, LD_ADDR, LD_WC, ARMED, XFER, FINISH.
REQ-018 IDLE: instr_out = NOP (1), data_oe=0, busy=0; start=1 latches cfg_ctrl/cfg_addr/cfg_count, clears xfer_cnt, moves to WR_CTRL.
REQ-019 WR_CTRL (1 cycle): instr_out=0, data_out=latched ctrl (zero-extended), data_oe=1; next LD_ADDR.
REQ-020 LD_ADDR (1 cycle): instr_out=5, data_out=latched addr, data_oe=1; next LD_WC, or ARMED if mode=2.
REQ-021 LD_WC (1 cycle): instr_out=6, data_out=latched count, data_oe=1; next ARMED.
REQ-022 ARMED: instr_out=NOP; am_done=1 (mode!=2) -> FINISH; else xfer_req=1 -> XFER.
REQ-023 XFER (exactly 1 cycle): instr_out=7, xfer_ack=1, xfer_cnt+1 modulo 2^DATA_LENGTH; next ARMED.
REQ-024 Beat latency: xfer_req seen in ARMED at cycle n -> xfer_ack at n+1; continuous xfer_req yields at most one ack every 2 cycles.
REQ-025 FINISH (1 cycle): done=1; next IDLE.
REQ-026 busy=1 in every state except IDLE; start while busy=1 SHALL be ignored.
REQ-027 Mode 2 (word counter disabled): am_done ignored; program ends only by abort.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, aborted=1 for 1 cycle, done stays 0; abort in IDLE has no effect.
REQ-029 Priority in ARMED: abort > am_done > xfer_req; on simultaneous am_done and xfer_req no ack issued.
REQ-030 done, aborted, xfer_ack SHALL be single-cycle pulses; all outputs registered.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, instr_out=1, data_out=0, data_oe=0, busy=0, done=0, aborted=0, xfer_ack=0, xfer_cnt=0, latched config=0.
REQ-032 Reset mid-program SHALL abandon it without asserting done or aborted.

Structure
REQ-033 Am2940 instruction codes (0,1,5,6,7), NOP and state encodings SHALL live in the shared header next to the length definitions.
REQ-034 One sub-module SHALL exist: beat_counter (DATA_LENGTH-bit clear/increment counter for xfer_cnt); the FSM stays in dma_sequencer.

Verification
REQ-035 start, ctrl=0, addr=0x40, count=3 -> instr_out 0,5,6 on 3 consecutive cycles with data_out 0x00,0x40,0x03, then busy=1, instr_out=1.
REQ-036 ARMED, xfer_req held high 6 cycles, am_done after 3rd beat -> 3 xfer_ack pulses each with instr_out=7, xfer_cnt=3, done pulse, busy=0.
REQ-037 ctrl=2 (mode 2) -> LD_WC skipped; am_done=1 ignored; abort -> aborted=1, done=0, IDLE.
REQ-038 ARMED, am_done and xfer_req asserted same cycle -> no xfer_ack, xfer_cnt unchanged, done next cycle.
REQ-039 255 beats then 1 more (DATA_LENGTH=8) -> xfer_cnt wraps 0xFF->0x00; rst_n low during LD_ADDR -> all outputs at reset values same cycle.
REQ-040 start pulsed while busy -> latched config unchanged, no restart.

Source files
------------

// File: rtl/dma_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_sequencer_pkg
// Description : Shared lengths, Am2940 instruction codes, word-count modes and
//               sequencer state encoding for the DMA sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_sequencer_pkg;

  // Default widths of the Am2940 instruction, control word and data path
  localparam int c_INSTR_LENGTH = 3;
  localparam int c_CTRL_LENGTH  = 3;
  localparam int c_DATA_LENGTH  = 8;

  // Am2940 instruction codes used by the sequencer
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_WR_CTRL   = 3'd0;
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_RD_CTRL   = 3'd1;
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_LD_ADDR   = 3'd5;
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_LD_WC     = 3'd6;
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_ENABLE    = 3'd7;
  // Reading the control register has no side effect, so it doubles as NOP
  localparam logic [c_INSTR_LENGTH-1:0] c_AM_NOP       = c_AM_RD_CTRL;

  // Word-count mode in which the core's word counter is disabled
  localparam logic [1:0] c_MODE_NO_WC = 2'd2;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CTRL = 3'd1,
    S_LD_ADDR = 3'd2,
    S_LD_WC   = 3'd3,
    S_ARMED   = 3'd4,
    S_XFER    = 3'd5,
    S_FINISH  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dma_sequencer_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : beat_counter
// Description : Clear/increment counter of granted transfer beats; wraps
//               modulo 2^DATA_LENGTH. Clear wins over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_counter
  import dma_sequencer_pkg::*;
#(
  parameter int DATA_LENGTH = c_DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [DATA_LENGTH-1:0] count_o
);

  logic [DATA_LENGTH-1:0] count_q;
  logic [DATA_LENGTH-1:0] count_d;

  // Next count: clear on a new program, otherwise step on each beat
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + DATA_LENGTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/dma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dma_sequencer
// Description : Programs an Am2940 DMA address generator (control word,
//               address, word count), then grants single-cycle transfer
//               beats until the core reports DONE or the program is aborted.
//               All outputs are registered from the next-state decode.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_sequencer
  import dma_sequencer_pkg::*;
#(
  parameter int INSTR_LENGTH = c_INSTR_LENGTH,
  parameter int CTRL_LENGTH  = c_CTRL_LENGTH,
  parameter int DATA_LENGTH  = c_DATA_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CTRL_LENGTH-1:0]  cfg_ctrl,
  input  logic [DATA_LENGTH-1:0]  cfg_addr,
  input  logic [DATA_LENGTH-1:0]  cfg_count,
  input  logic                    xfer_req,
  input  logic                    am_done,
  input  logic                    abort,
  output logic [INSTR_LENGTH-1:0] instr_out,
  output logic [DATA_LENGTH-1:0]  data_out,
  output logic                    data_oe,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    xfer_ack,
  output logic [DATA_LENGTH-1:0]  xfer_cnt
);

  state_e                  state_q, state_d;
  logic [CTRL_LENGTH-1:0]  ctrl_q, ctrl_d;
  logic [DATA_LENGTH-1:0]  addr_q, addr_d;
  logic [DATA_LENGTH-1:0]  count_q, count_d;

  logic [INSTR_LENGTH-1:0] instr_q, instr_d;
  logic [DATA_LENGTH-1:0]  data_q, data_d;
  logic                    data_oe_q, data_oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    ack_q, ack_d;

  logic                    w_no_wc;
  logic                    w_cnt_clr;
  logic                    w_cnt_inc;

  // Word counter disabled: the program only ends by abort
  assign w_no_wc = (ctrl_q[1:0] == c_MODE_NO_WC);

  // Next state, configuration latch and counter controls
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    count_d   = count_q;
    w_cnt_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR_CTRL;
          ctrl_d    = cfg_ctrl;
          addr_d    = cfg_addr;
          count_d   = cfg_count;
          w_cnt_clr = 1'b1;
        end
      end
      S_WR_CTRL: state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = w_no_wc ? S_ARMED : S_LD_WC;
      S_LD_WC:   state_d = S_ARMED;
      S_ARMED: begin
        // DONE outranks a beat request; a pending request gets no ack
        if (am_done && !w_no_wc) begin
          state_d = S_FINISH;
        end else if (xfer_req) begin
          state_d = S_XFER;
        end
      end
      S_XFER:    state_d = S_ARMED;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // Abort outranks everything once a program is running
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  assign w_cnt_inc = (state_d == S_XFER);

  // Output decode from the state about to be entered, so outputs are registered
  always_comb begin
    instr_d   = INSTR_LENGTH'(c_AM_NOP);
    data_d    = '0;
    data_oe_d = 1'b0;
    unique case (state_d)
      S_WR_CTRL: begin
        instr_d   = INSTR_LENGTH'(c_AM_WR_CTRL);
        data_d    = DATA_LENGTH'(ctrl_d);
        data_oe_d = 1'b1;
      end
      S_LD_ADDR: begin
        instr_d   = INSTR_LENGTH'(c_AM_LD_ADDR);
        data_d    = addr_d;
        data_oe_d = 1'b1;
      end
      S_LD_WC: begin
        instr_d   = INSTR_LENGTH'(c_AM_LD_WC);
        data_d    = count_d;
        data_oe_d = 1'b1;
      end
      S_XFER: instr_d = INSTR_LENGTH'(c_AM_ENABLE);
      default: ;
    endcase
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    aborted_d = abort && (state_q != S_IDLE);
    ack_d     = (state_d == S_XFER);
  end

  // State, configuration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      instr_q   <= INSTR_LENGTH'(c_AM_NOP);
      data_q    <= '0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      instr_q   <= instr_d;
      data_q    <= data_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ack_q     <= ack_d;
    end
  end

  beat_counter #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_cnt_clr),
    .inc_i   (w_cnt_inc),
    .count_o (xfer_cnt)
  );

  assign instr_out = instr_q;
  assign data_out  = data_q;
  assign data_oe   = data_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign xfer_ack  = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_sequencer
// Description : Randomised scoreboard bench for dma_sequencer. The driver
//               predicts the event stream (register loads, beat acks, done,
//               aborted) from the program rules; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_sequencer;

  localparam int K_LOAD = 0;
  localparam int K_ACK  = 1;
  localparam int K_DONE = 2;
  localparam int K_ABRT = 3;

  typedef struct {
    int         kind;
    logic [2:0] instr;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] cfg_ctrl;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_count;
  logic       xfer_req;
  logic       am_done;
  logic       abort;
  logic [2:0] instr_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       xfer_ack;
  logic [7:0] xfer_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  dma_sequencer #(
    .INSTR_LENGTH (3),
    .CTRL_LENGTH  (3),
    .DATA_LENGTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_ctrl  (cfg_ctrl),
    .cfg_addr  (cfg_addr),
    .cfg_count (cfg_count),
    .xfer_req  (xfer_req),
    .am_done   (am_done),
    .abort     (abort),
    .instr_out (instr_out),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .xfer_ack  (xfer_ack),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int kind, input logic [2:0] instr, input logic [7:0] data,
                               input logic [7:0] cnt, input logic bsy);
    exp_t e;
    e.kind  = kind;
    e.instr = instr;
    e.data  = data;
    e.cnt   = cnt;
    e.busy  = bsy;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    xfer_req = 1'b0;
    am_done  = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"},   32'(instr_out), 32'd1);
    check({tag, "_data"},    32'(data_out),  32'd0);
    check({tag, "_oe"},      32'(data_oe),   32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_done"},    32'(done),      32'd0);
    check({tag, "_aborted"}, 32'(aborted),   32'd0);
    check({tag, "_ack"},     32'(xfer_ack),  32'd0);
    check({tag, "_cnt"},     32'(xfer_cnt),  32'd0);
  endtask

  // Garbage configuration presented while busy; it must never be latched
  task automatic junk_start();
    start     = 1'(($urandom % 2));
    cfg_ctrl  = 3'($urandom);
    cfg_addr  = 8'($urandom);
    cfg_count = 8'($urandom);
  endtask

  // One transfer program. end_abort=0 ends by DONE (only possible when the
  // word counter is enabled), abort_load>=0 aborts during that register load.
  task automatic run_program(input logic [2:0] ctrl, input logic [7:0] addr, input logic [7:0] wc,
                             input int armed_cycles, input bit end_abort, input int abort_load,
                             input bit req_always);
    int         loads;
    bit         no_wc;
    bit         ready;
    bit         req;
    logic [7:0] beats;
    logic [7:0] load_data[3];
    logic [2:0] load_instr[3];
    no_wc = (ctrl[1:0] == 2'd2);
    loads = no_wc ? 2 : 3;
    load_data[0] = {5'd0, ctrl};
    load_data[1] = addr;
    load_data[2] = wc;
    load_instr[0] = 3'd0;
    load_instr[1] = 3'd5;
    load_instr[2] = 3'd6;
    beats = 8'd0;

    idle_inputs();
    start     = 1'b1;
    cfg_ctrl  = ctrl;
    cfg_addr  = addr;
    cfg_count = wc;
    tick();
    for (int j = 0; j < loads; j++) begin
      push(K_LOAD, load_instr[j], load_data[j], 8'd0, 1'b1);
      junk_start();
      xfer_req = 1'(($urandom % 2));
      am_done  = 1'(($urandom % 2));
      abort    = (j == abort_load);
      tick();
      if (j == abort_load) begin
        push(K_ABRT, 3'd1, 8'd0, 8'd0, 1'b0);
        idle_inputs();
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        return;
      end
    end

    // Armed: a request is granted whenever the previous cycle was not a beat
    ready = 1'b1;
    for (int i = 0; i < armed_cycles; i++) begin
      req = req_always ? 1'b1 : 1'(($urandom % 2));
      junk_start();
      xfer_req = req;
      am_done  = no_wc ? 1'(($urandom % 2)) : 1'b0;
      abort    = 1'b0;
      tick();
      if (ready && req) begin
        beats = beats + 8'd1;
        push(K_ACK, 3'd7, 8'd0, beats, 1'b1);
        ready = 1'b0;
      end else begin
        ready = 1'b1;
      end
    end
    if (!ready) begin
      xfer_req = 1'b0;
      am_done  = 1'b0;
      tick();
    end

    if (end_abort || no_wc) begin
      junk_start();
      xfer_req = 1'(($urandom % 2));
      am_done  = 1'(($urandom % 2));
      abort    = 1'b1;
      tick();
      push(K_ABRT, 3'd1, 8'd0, beats, 1'b0);
      idle_inputs();
    end else begin
      start    = 1'b0;
      xfer_req = req_always ? 1'b1 : 1'(($urandom % 2));
      am_done  = 1'b1;
      abort    = 1'b0;
      tick();
      push(K_DONE, 3'd1, 8'd0, beats, 1'b1);
      // FINISH is still busy: a start here must be ignored
      junk_start();
      am_done  = 1'b0;
      xfer_req = 1'(($urandom % 2));
      tick();
      idle_inputs();
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every output event pops one prediction
  always @(negedge clk) begin : monitor
    int   nflags;
    int   kind;
    exp_t e;
    if (rst_n === 1'b1) begin
      nflags = int'(data_oe) + int'(xfer_ack) + int'(done) + int'(aborted);
      if (nflags > 1) begin
        check("one_event_per_cycle", 32'(nflags), 32'd1);
      end else if (nflags == 0) begin
        check("nop_instr", 32'(instr_out), 32'd1);
      end else begin
        kind = data_oe ? K_LOAD : xfer_ack ? K_ACK : done ? K_DONE : K_ABRT;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("event_instr", 32'(instr_out), 32'(e.instr));
          check("event_busy", 32'(busy), 32'(e.busy));
          if (e.kind == K_LOAD) begin
            check("load_data", 32'(data_out), 32'(e.data));
          end else begin
            check("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         ab_load;
    logic [2:0] c;
    rst_n     = 1'b0;
    cfg_ctrl  = 3'd0;
    cfg_addr  = 8'd0;
    cfg_count = 8'd0;
    idle_inputs();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Canonical program: loads 0,5,6 then three beats and DONE
    run_program(3'd0, 8'h40, 8'h03, 6, 1'b0, -1, 1'b1);
    // Word counter disabled: no LD_WC, DONE ignored, abort ends it
    run_program(3'd2, 8'h12, 8'h34, 5, 1'b1, -1, 1'b0);
    // DONE and request together on the first armed cycle: no ack
    run_program(3'd5, 8'hA5, 8'h5A, 0, 1'b0, -1, 1'b1);
    // Abort while loading the address
    run_program(3'd1, 8'h77, 8'h10, 0, 1'b1, 1, 1'b0);
    // 257 beats: counter wraps through 0xFF -> 0x00
    run_program(3'd6, 8'h80, 8'h00, 514, 1'b1, -1, 1'b1);

    // Reset during LD_ADDR: outputs return to reset values immediately
    idle_inputs();
    start     = 1'b1;
    cfg_ctrl  = 3'd1;
    cfg_addr  = 8'h33;
    cfg_count = 8'h44;
    tick();
    push(K_LOAD, 3'd0, 8'h01, 8'd0, 1'b1);
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int p = 0; p < 30; p++) begin
      c       = 3'($urandom);
      ab_load = (($urandom % 6) == 0) ? int'($urandom % 3) : -1;
      run_program(c, 8'($urandom), 8'($urandom), int'($urandom_range(0, 12)),
                  1'(($urandom % 3) == 0), ab_load, 1'(($urandom % 4) == 0));
      repeat ($urandom % 3) tick();
    end

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
